// File: rtl/nf10_axis_record_arbiter.sv
// Packet-granular round-robin merge of four AXI Stream slaves onto one registered master.
// Define NF10_AXIS_RECORD_ARB_SRC_TAG_EN to stamp the source port index into the top two tuser bits.
module nf10_axis_record_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              aclk,
    input  logic                              aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    input  logic                              s0_axis_tvalid,
    output logic                              s0_axis_tready,
    input  logic                              s0_axis_tlast,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    input  logic                              s1_axis_tvalid,
    output logic                              s1_axis_tready,
    input  logic                              s1_axis_tlast,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s2_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s2_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s2_axis_tuser,
    input  logic                              s2_axis_tvalid,
    output logic                              s2_axis_tready,
    input  logic                              s2_axis_tlast,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s3_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s3_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s3_axis_tuser,
    input  logic                              s3_axis_tvalid,
    output logic                              s3_axis_tready,
    input  logic                              s3_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,

    output logic [1:0]                        grant_id,
    output logic                              grant_active
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic {IDLE, PASS} state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [DW-1:0]   m_tdata_q;
    logic [SW-1:0]   m_tstrb_q;
    logic [UW-1:0]   m_tuser_q;
    logic            m_tvalid_q;
    logic            m_tlast_q;

    logic [DW-1:0]   s_tdata [4];
    logic [SW-1:0]   s_tstrb [4];
    logic [UW-1:0]   s_tuser [4];
    logic [3:0]      s_tvalid;
    logic [3:0]      s_tlast;
    logic [3:0]      s_tready;

    logic            out_free;
    logic            xfer;
    logic [1:0]      pick;
    logic [1:0]      idx;
    logic            found;
    logic [UW-1:0]   sel_user;

    assign s_tdata[0] = s0_axis_tdata;
    assign s_tdata[1] = s1_axis_tdata;
    assign s_tdata[2] = s2_axis_tdata;
    assign s_tdata[3] = s3_axis_tdata;
    assign s_tstrb[0] = s0_axis_tstrb;
    assign s_tstrb[1] = s1_axis_tstrb;
    assign s_tstrb[2] = s2_axis_tstrb;
    assign s_tstrb[3] = s3_axis_tstrb;
    assign s_tuser[0] = s0_axis_tuser;
    assign s_tuser[1] = s1_axis_tuser;
    assign s_tuser[2] = s2_axis_tuser;
    assign s_tuser[3] = s3_axis_tuser;
    assign s_tvalid   = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    assign s_tlast    = {s3_axis_tlast, s2_axis_tlast, s1_axis_tlast, s0_axis_tlast};

    assign s0_axis_tready = s_tready[0];
    assign s1_axis_tready = s_tready[1];
    assign s2_axis_tready = s_tready[2];
    assign s3_axis_tready = s_tready[3];

    assign out_free = !m_tvalid_q || m_axis_tready;

    // Rotating search starts just after the last grant; k=4 wraps back to that same port.
    always_comb begin
        pick  = grant_q;
        found = 1'b0;
        idx   = grant_q;
        for (int k = 1; k <= 4; k++) begin
            idx = grant_q + 2'(k);
            if (!found && s_tvalid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        s_tready = 4'b0000;
        xfer     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = PASS;
                end
            end
            PASS: begin
                s_tready[grant_q] = out_free;
                xfer              = s_tvalid[grant_q] && out_free;
                if (xfer && s_tlast[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_user = s_tuser[grant_q];
`ifdef NF10_AXIS_RECORD_ARB_SRC_TAG_EN
        sel_user[UW-1 -: 2] = grant_q;
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Output stage only advances when the downstream slot is empty or being drained.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata_q  <= '0;
            m_tstrb_q  <= '0;
            m_tuser_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else if (out_free) begin
            m_tvalid_q <= xfer;
            m_tlast_q  <= xfer && s_tlast[grant_q];
            if (xfer) begin
                m_tdata_q <= s_tdata[grant_q];
                m_tstrb_q <= s_tstrb[grant_q];
                m_tuser_q <= sel_user;
            end
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tstrb  = m_tstrb_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign grant_id      = grant_q;
    assign grant_active  = (state_q == PASS);

endmodule

// File: tb/tb_nf10_axis_record_arbiter.sv
// Directed bench for nf10_axis_record_arbiter: rotation, backpressure, single-beat packets, reset and tuser handling.
module tb_nf10_axis_record_arbiter;

    logic           aclk;
    logic           aresetn;
    logic [255:0]   s_dat [4];
    logic [31:0]    s_stb [4];
    logic [127:0]   s_usr [4];
    logic [3:0]     s_vld;
    logic [3:0]     s_lst;
    logic [3:0]     s_rdy;
    logic [255:0]   m_dat;
    logic [31:0]    m_stb;
    logic [127:0]   m_usr;
    logic           m_vld;
    logic           m_rdy;
    logic           m_lst;
    logic [1:0]     gid;
    logic           gact;

    int checks = 0;
    int errors = 0;

    int pkts [4];
    int beat [4];
    int plen [4];
    int pcnt [4];

    nf10_axis_record_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axis_tdata(s_dat[0]), .s0_axis_tstrb(s_stb[0]), .s0_axis_tuser(s_usr[0]),
        .s0_axis_tvalid(s_vld[0]), .s0_axis_tready(s_rdy[0]), .s0_axis_tlast(s_lst[0]),
        .s1_axis_tdata(s_dat[1]), .s1_axis_tstrb(s_stb[1]), .s1_axis_tuser(s_usr[1]),
        .s1_axis_tvalid(s_vld[1]), .s1_axis_tready(s_rdy[1]), .s1_axis_tlast(s_lst[1]),
        .s2_axis_tdata(s_dat[2]), .s2_axis_tstrb(s_stb[2]), .s2_axis_tuser(s_usr[2]),
        .s2_axis_tvalid(s_vld[2]), .s2_axis_tready(s_rdy[2]), .s2_axis_tlast(s_lst[2]),
        .s3_axis_tdata(s_dat[3]), .s3_axis_tstrb(s_stb[3]), .s3_axis_tuser(s_usr[3]),
        .s3_axis_tvalid(s_vld[3]), .s3_axis_tready(s_rdy[3]), .s3_axis_tlast(s_lst[3]),
        .m_axis_tdata(m_dat), .m_axis_tstrb(m_stb), .m_axis_tuser(m_usr),
        .m_axis_tvalid(m_vld), .m_axis_tready(m_rdy), .m_axis_tlast(m_lst),
        .grant_id(gid), .grant_active(gact)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Beat payload encodes packet count, source port and beat index.
    function automatic logic [255:0] edat(input int p, input int pk, input int b);
        return 256'((pk << 8) | (p << 4) | b);
    endfunction

    function automatic logic [31:0] estb(input int p, input int pk, input int b);
        return ~32'((pk << 8) | (p << 4) | b);
    endfunction

    function automatic logic [127:0] esrc_usr(input int p, input int pk, input int b);
        logic [127:0] u;
        if (p == 2) u = '0;
        else        u = {2'b11, 126'((pk << 8) | (p << 4) | b)};
        return u;
    endfunction

    function automatic logic [127:0] eusr(input int p, input int pk, input int b);
        logic [127:0] u;
        u = esrc_usr(p, pk, b);
`ifdef NF10_AXIS_RECORD_ARB_SRC_TAG_EN
        u[127:126] = 2'(p);
`endif
        return u;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_src();
        for (int i = 0; i < 4; i++) begin
            s_vld[i] = (pkts[i] > 0);
            s_lst[i] = (beat[i] == plen[i] - 1);
            s_dat[i] = edat(i, pcnt[i], beat[i]);
            s_stb[i] = estb(i, pcnt[i], beat[i]);
            s_usr[i] = esrc_usr(i, pcnt[i], beat[i]);
        end
    endtask

    // Advance one clock; sources step to their next beat only after a handshake.
    task automatic tick();
        logic [3:0] hs;
        #2;
        hs = s_vld & s_rdy;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                beat[i]++;
                if (beat[i] == plen[i]) begin
                    beat[i] = 0;
                    pcnt[i]++;
                    pkts[i]--;
                end
            end
        end
        upd_src();
    endtask

    task automatic chk_beat(input string tag, input int p, input int pk, input int b, input logic last);
        chk({tag, ".vld"},  256'(m_vld), 256'(1'b1));
        chk({tag, ".dat"},  m_dat, edat(p, pk, b));
        chk({tag, ".stb"},  256'(m_stb), 256'(estb(p, pk, b)));
        chk({tag, ".usr"},  256'(m_usr), 256'(eusr(p, pk, b)));
        chk({tag, ".last"}, 256'(m_lst), 256'(last));
    endtask

    task automatic reset_dut();
        aresetn = 1'b0;
        m_rdy   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pkts[i] = 0;
            beat[i] = 0;
            plen[i] = 1;
            pcnt[i] = 0;
        end
        upd_src();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        int slot;
        int pi;
        aresetn = 1'b0;
        m_rdy   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pkts[i] = 0;
            beat[i] = 0;
            plen[i] = 1;
            pcnt[i] = 0;
        end
        upd_src();

        // Reset state
        reset_dut();
        chk("rst.vld",  256'(m_vld), 256'(1'b0));
        chk("rst.last", 256'(m_lst), 256'(1'b0));
        chk("rst.dat",  m_dat, 256'(0));
        chk("rst.stb",  256'(m_stb), 256'(0));
        chk("rst.usr",  256'(m_usr), 256'(0));
        chk("rst.gid",  256'(gid), 256'(2'd3));
        chk("rst.gact", 256'(gact), 256'(1'b0));
        chk("rst.rdy",  256'(s_rdy), 256'(4'b0000));

        // s1 three-beat packet: first output two cycles after first tvalid
        plen[1] = 3;
        pkts[1] = 1;
        upd_src();
        #1;
        chk("t1.idle_rdy", 256'(s_rdy), 256'(4'b0000));
        tick();
        chk("t1.gact", 256'(gact), 256'(1'b1));
        chk("t1.gid",  256'(gid), 256'(2'd1));
        chk("t1.vld0", 256'(m_vld), 256'(1'b0));
        #1;
        chk("t1.rdy", 256'(s_rdy), 256'(4'b0010));
        tick();
        chk_beat("t1.b0", 1, 0, 0, 1'b0);
        tick();
        chk_beat("t1.b1", 1, 0, 1, 1'b0);
        tick();
        chk_beat("t1.b2", 1, 0, 2, 1'b1);
        chk("t1.gact_end", 256'(gact), 256'(1'b0));
        tick();
        chk("t1.vld_end", 256'(m_vld), 256'(1'b0));
        chk("t1.gid_end", 256'(gid), 256'(2'd1));

        // All four ports continuously offer two-beat packets: order 0,1,2,3,0,1
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            plen[i] = 2;
            pkts[i] = 2;
        end
        upd_src();
        tick();
        tick();
        for (int k = 0; k < 18; k++) begin
            slot = k % 3;
            pi   = k / 3;
            if (slot < 2) chk_beat($sformatf("t2.k%0d", k), pi % 4, pi / 4, slot, slot == 1);
            else          chk($sformatf("t2.gap%0d", k), 256'(m_vld), 256'(1'b0));
            tick();
        end

        // s2 four-beat packet with five stalled cycles starting at beat 2
        reset_dut();
        plen[2] = 4;
        pkts[2] = 1;
        upd_src();
        tick();
        tick();
        chk_beat("t3.b0", 2, 0, 0, 1'b0);
        tick();
        chk_beat("t3.b1", 2, 0, 1, 1'b0);
        m_rdy = 1'b0;
        #1;
        chk("t3.stall_rdy0", 256'(s_rdy), 256'(4'b0000));
        for (int k = 1; k < 5; k++) begin
            tick();
            chk_beat($sformatf("t3.hold%0d", k), 2, 0, 1, 1'b0);
            chk($sformatf("t3.stall_rdy%0d", k), 256'(s_rdy), 256'(4'b0000));
        end
        tick();
        chk_beat("t3.hold5", 2, 0, 1, 1'b0);
        m_rdy = 1'b1;
        #1;
        chk("t3.resume_rdy", 256'(s_rdy), 256'(4'b0100));
        tick();
        chk_beat("t3.b2", 2, 0, 2, 1'b0);
        tick();
        chk_beat("t3.b3", 2, 0, 3, 1'b1);
        tick();
        chk("t3.vld_end", 256'(m_vld), 256'(1'b0));

        // s3 single-beat packets back to back: valid toggles 1,0,1,0
        reset_dut();
        plen[3] = 1;
        pkts[3] = 3;
        upd_src();
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t4.vld%0d", k), 256'(m_vld), 256'((k % 2) == 0));
            chk($sformatf("t4.gid%0d", k), 256'(gid), 256'(2'd3));
            if ((k % 2) == 0) chk_beat($sformatf("t4.p%0d", k / 2), 3, k / 2, 0, 1'b1);
            tick();
        end

        // Reset during a five-beat s0 packet, then an s1 packet after release
        reset_dut();
        plen[0] = 5;
        pkts[0] = 1;
        upd_src();
        tick();
        tick();
        chk_beat("t5.b0", 0, 0, 0, 1'b0);
        tick();
        chk_beat("t5.b1", 0, 0, 1, 1'b0);
        #1;
        aresetn = 1'b0;
        #1;
        chk("t5.async_vld",  256'(m_vld), 256'(1'b0));
        chk("t5.async_dat",  m_dat, 256'(0));
        chk("t5.async_gid",  256'(gid), 256'(2'd3));
        chk("t5.async_gact", 256'(gact), 256'(1'b0));
        chk("t5.async_rdy",  256'(s_rdy), 256'(4'b0000));
        pkts[0] = 0;
        beat[0] = 0;
        upd_src();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        plen[1] = 3;
        pkts[1] = 1;
        upd_src();
        tick();
        chk("t5.gid", 256'(gid), 256'(2'd1));
        tick();
        chk_beat("t5.s1b0", 1, 0, 0, 1'b0);
        tick();
        chk_beat("t5.s1b1", 1, 0, 1, 1'b0);
        tick();
        chk_beat("t5.s1b2", 1, 0, 2, 1'b1);
        tick();
        chk("t5.vld_end", 256'(m_vld), 256'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
